// File: rtl/multi_reaction_core_if.sv
// multi_reaction_core_if: bundles the reaction core's control inputs and
// result outputs so the core and its environment share one port.
//   slave  : core side  (inputs tick_1ms/start/react/clr_best/rand_val,
//                        outputs led/busy/round_idx/cur_time/fail/avg_time/
//                        winner/winner_valid/best_time/done)
//   master : environment side (directions mirrored)
interface multi_reaction_core_if #(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned ROUNDS    = 4,
  parameter int unsigned TIME_W    = 16,
  parameter int unsigned DELAY_W   = 12
);
  localparam int unsigned LOG_R  = $clog2(ROUNDS);
  localparam int unsigned RIDX_W = (LOG_R > 0) ? LOG_R : 1;
  localparam int unsigned WIN_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  logic                          tick_1ms;
  logic                          start;
  logic [N_PLAYERS-1:0]          react;
  logic                          clr_best;
  logic [DELAY_W-1:0]            rand_val;

  logic                          led;
  logic                          busy;
  logic [RIDX_W-1:0]             round_idx;
  logic [N_PLAYERS*TIME_W-1:0]   cur_time;
  logic [N_PLAYERS-1:0]          fail;
  logic [N_PLAYERS*TIME_W-1:0]   avg_time;
  logic [WIN_W-1:0]              winner;
  logic                          winner_valid;
  logic [TIME_W-1:0]             best_time;
  logic                          done;

  modport slave (
    input  tick_1ms, start, react, clr_best, rand_val,
    output led, busy, round_idx, cur_time, fail, avg_time,
           winner, winner_valid, best_time, done
  );

  modport master (
    output tick_1ms, start, react, clr_best, rand_val,
    input  led, busy, round_idx, cur_time, fail, avg_time,
           winner, winner_valid, best_time, done
  );
endinterface

// File: rtl/multi_reaction_core.sv
// multi_reaction_core: N-player, multi-round reaction-time match controller.
// Each round waits MIN_DELAY_MS + rand_val ms, lights the LED and latches
// every player's reaction time; false starts and timeouts score TIMEOUT_MS.
// Keeps per-player sums/averages, the match winner and an all-time best.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : multi_reaction_core_if.slave (tick/start/react/clr_best/
//                rand_val in; led/busy/round_idx/cur_time/fail/avg_time/
//                winner/winner_valid/best_time/done out)
// Optional build macro REACT_HOLD_CHECK_EN: ARM waits until every react
// button is released before loading the countdown.
module multi_reaction_core #(
  parameter int unsigned N_PLAYERS    = 2,
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned TIME_W       = 16,
  parameter int unsigned DELAY_W      = 12,
  parameter int unsigned MIN_DELAY_MS = 500,
  parameter int unsigned TIMEOUT_MS   = 10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_reaction_core_if.slave  bus
);

  localparam int unsigned LOG_R  = $clog2(ROUNDS);
  localparam int unsigned RIDX_W = (LOG_R > 0) ? LOG_R : 1;
  localparam int unsigned WIN_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int unsigned SUM_W  = TIME_W + LOG_R;
  localparam int unsigned DLY_W  = $clog2(MIN_DELAY_MS + 2**DELAY_W);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_COUNTDOWN, S_REACT, S_ROUND_END, S_MATCH_END, S_SHOW
  } state_e;

  state_e                            state_q;
  logic                              start_prev_q;
  logic [N_PLAYERS-1:0]              react_prev_q;
  logic [DLY_W-1:0]                  delay_q;
  logic [TIME_W-1:0]                 ms_cnt_q;
  logic [N_PLAYERS-1:0]              resolved_q;
  logic                              match_over_q;
  logic                              any_valid_q;
  logic [N_PLAYERS-1:0][SUM_W-1:0]   sum_q;

  logic                              led_q;
  logic                              busy_q;
  logic [RIDX_W-1:0]                 round_idx_q;
  logic [N_PLAYERS-1:0][TIME_W-1:0]  cur_q;
  logic [N_PLAYERS-1:0]              fail_q;
  logic [N_PLAYERS-1:0][TIME_W-1:0]  avg_q;
  logic [WIN_W-1:0]                  winner_q;
  logic                              winner_valid_q;
  logic [TIME_W-1:0]                 best_q;
  logic                              done_q;

  logic                              start_edge_c;
  logic [N_PLAYERS-1:0]              react_edge_c;
  logic [N_PLAYERS-1:0]              cd_fail_c;
  logic [N_PLAYERS-1:0]              rx_res_c;
  logic                              arm_go_c;
  logic [TIME_W-1:0]                 best_d;
  logic [SUM_W-1:0]                  win_sum_c;
  logic [WIN_W-1:0]                  win_idx_c;

  // Rising-edge detection against the previous-cycle samples.
  assign start_edge_c = bus.start & ~start_prev_q;
  assign react_edge_c = bus.react & ~react_prev_q;
  assign cd_fail_c    = fail_q | react_edge_c;
  assign rx_res_c     = resolved_q | react_edge_c;

  // ARM either leaves unconditionally or waits for all buttons released.
`ifdef REACT_HOLD_CHECK_EN
  assign arm_go_c = ~|bus.react;
`else
  assign arm_go_c = 1'b1;
`endif

  // Best reaction including this round's non-failed times.
  always_comb begin
    best_d = best_q;
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      if (!fail_q[i] && (cur_q[i] < best_d)) best_d = cur_q[i];
    end
  end

  // Lowest match sum; strict compare keeps ties on the lowest index.
  always_comb begin
    win_sum_c = sum_q[0];
    win_idx_c = '0;
    for (int i = 1; i < int'(N_PLAYERS); i++) begin
      if (sum_q[i] < win_sum_c) begin
        win_sum_c = sum_q[i];
        win_idx_c = WIN_W'(i);
      end
    end
  end

  // Match FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      start_prev_q   <= 1'b0;
      react_prev_q   <= '0;
      delay_q        <= '0;
      ms_cnt_q       <= '0;
      resolved_q     <= '0;
      match_over_q   <= 1'b0;
      any_valid_q    <= 1'b0;
      sum_q          <= '0;
      led_q          <= 1'b0;
      busy_q         <= 1'b0;
      round_idx_q    <= '0;
      cur_q          <= '0;
      fail_q         <= '0;
      avg_q          <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      best_q         <= '1;
      done_q         <= 1'b0;
    end else begin
      start_prev_q <= bus.start;
      react_prev_q <= bus.react;
      done_q       <= 1'b0;

      // clr_best overrides the ROUND_END update.
      if (bus.clr_best)                best_q <= '1;
      else if (state_q == S_ROUND_END) best_q <= best_d;

      case (state_q)
        S_IDLE, S_SHOW: begin
          if (start_edge_c) begin
            if ((state_q == S_IDLE) || match_over_q) begin
              sum_q          <= '0;
              round_idx_q    <= '0;
              winner_valid_q <= 1'b0;
              any_valid_q    <= 1'b0;
              match_over_q   <= 1'b0;
            end
            busy_q  <= 1'b1;
            state_q <= S_ARM;
          end
        end

        S_ARM: begin
          if (arm_go_c) begin
            delay_q    <= DLY_W'(MIN_DELAY_MS) + DLY_W'(bus.rand_val);
            cur_q      <= '0;
            fail_q     <= '0;
            resolved_q <= '0;
            state_q    <= S_COUNTDOWN;
          end
        end

        S_COUNTDOWN: begin
          // Any press before the LED is a false start.
          for (int i = 0; i < int'(N_PLAYERS); i++) begin
            if (react_edge_c[i] && !fail_q[i]) begin
              fail_q[i] <= 1'b1;
              cur_q[i]  <= TIME_W'(TIMEOUT_MS);
            end
          end
          resolved_q <= cd_fail_c;
          if (&cd_fail_c) begin
            busy_q  <= 1'b0;
            state_q <= S_ROUND_END;
          end else if (bus.tick_1ms) begin
            if (delay_q != '0) begin
              delay_q <= delay_q - DLY_W'(1);
            end else begin
              led_q    <= 1'b1;
              ms_cnt_q <= '0;
              state_q  <= S_REACT;
            end
          end
        end

        S_REACT: begin
          if (ms_cnt_q >= TIME_W'(TIMEOUT_MS)) begin
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
              if (!resolved_q[i]) begin
                fail_q[i] <= 1'b1;
                cur_q[i]  <= TIME_W'(TIMEOUT_MS);
              end
            end
            resolved_q <= '1;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_ROUND_END;
          end else begin
            // Latch the pre-increment count if a tick coincides.
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
              if (react_edge_c[i] && !resolved_q[i]) cur_q[i] <= ms_cnt_q;
            end
            resolved_q <= rx_res_c;
            if (bus.tick_1ms) ms_cnt_q <= ms_cnt_q + TIME_W'(1);
            if (&rx_res_c) begin
              led_q   <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_ROUND_END;
            end
          end
        end

        S_ROUND_END: begin
          for (int i = 0; i < int'(N_PLAYERS); i++) begin
            sum_q[i] <= sum_q[i] + SUM_W'(cur_q[i]);
          end
          if (!(&fail_q)) any_valid_q <= 1'b1;
          if (round_idx_q == RIDX_W'(ROUNDS - 1)) begin
            state_q <= S_MATCH_END;
          end else begin
            round_idx_q <= round_idx_q + RIDX_W'(1);
            state_q     <= S_SHOW;
          end
        end

        S_MATCH_END: begin
          for (int i = 0; i < int'(N_PLAYERS); i++) begin
            avg_q[i] <= sum_q[i][SUM_W-1:LOG_R];
          end
          winner_q       <= win_idx_c;
          winner_valid_q <= any_valid_q;
          match_over_q   <= 1'b1;
          done_q         <= 1'b1;
          state_q        <= S_SHOW;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.led          = led_q;
  assign bus.busy         = busy_q;
  assign bus.round_idx    = round_idx_q;
  assign bus.cur_time     = cur_q;
  assign bus.fail         = fail_q;
  assign bus.avg_time     = avg_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.best_time    = best_q;
  assign bus.done         = done_q;

endmodule

// File: doc/multi_reaction_core.md
Name: multi_reaction_core

Overview:
- Parametrised successor to the single-player reaction state machine. Runs an N-player match of ROUNDS rounds.
- Each round: random delay, then LED on, then each player's reaction time is latched independently.
- False starts and timeouts are penalised. Per-player totals and averages, the match winner, and an all-time best single reaction are kept.
- Sits between the debouncers / clock_divider / lfsr_random and the display logic.

Parameters:
- N_PLAYERS, 2, number of react inputs (1..8).
- ROUNDS, 4, rounds per match; must be a power of 2 (2..16).
- TIME_W, 16, width of per-reaction time in ms.
- DELAY_W, 12, width of rand_val.
- MIN_DELAY_MS, 500, fixed offset added to rand_val.
- TIMEOUT_MS, 10000, reaction window length and the penalty value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick_1ms  in  1  one-cycle 1 ms strobe
- start  in  1  debounced start level; rising edge is used
- react  in  N_PLAYERS  debounced react levels; rising edges are used
- clr_best  in  1  clears best_time only
- rand_val  in  DELAY_W  random delay source
- led  out  1  stimulus LED
- busy  out  1  high in ARM, COUNTDOWN and REACT
- round_idx  out  clog2(ROUNDS)  current round number
- cur_time  out  N_PLAYERS*TIME_W  this round's time per player (player i at bits [i*TIME_W +: TIME_W])
- fail  out  N_PLAYERS  this round's fail flag per player
- avg_time  out  N_PLAYERS*TIME_W  match sum >> log2(ROUNDS); valid after done
- winner  out  clog2(N_PLAYERS) (min 1)  index of the winning player
- winner_valid  out  1  winner output is meaningful
- best_time  out  TIME_W  lowest valid reaction since reset / clr_best
- done  out  1  one-cycle pulse at match end

Behaviour:
- Reset values (rst_n=0 at a clk edge, from any state): state IDLE; led=0; busy=0; round_idx=0; cur_time=0; fail=0; sums=0; avg_time=0; winner=0; winner_valid=0; best_time=all ones; done=0. Edge-detect history registers are cleared as well.
- Edge detection: start and each react[i] are registered internally; a rising edge means current=1 and previous=0.
- IDLE / SHOW: led=0.
  - start edge in IDLE → new match: clear sums, round_idx=0, winner_valid=0 → ARM.
  - start edge in SHOW → next round → ARM.
  - start edge in SHOW after a match end → new match.
- ARM (1 cycle): delay_cnt = MIN_DELAY_MS + rand_val, zero-extended. Clear cur_time and fail → COUNTDOWN.
- COUNTDOWN:
  - On a tick with delay_cnt>0: decrement.
  - On a tick with delay_cnt==0: led=1, ms_cnt=0 → REACT.
  - react[i] edge → fail[i]=1 and cur_time[i]=TIMEOUT_MS; player i is ignored for the rest of the round.
  - If all players have failed → ROUND_END immediately; the LED never lights.
- REACT:
  - On each tick, ms_cnt increments.
  - react[i] edge for a not-yet-resolved player → cur_time[i]=ms_cnt. If the edge and a tick arrive in the same cycle, the pre-increment value is latched.
  - When all players are resolved → ROUND_END.
  - When ms_cnt reaches TIMEOUT_MS → every unresolved player gets fail=1 and cur_time=TIMEOUT_MS → ROUND_END.
  - led drops to 0 on leaving REACT.
- ROUND_END (1 cycle):
  - sum[i] += cur_time[i]; sum width is TIME_W+log2(ROUNDS), no overflow possible.
  - best_time = min(best_time, every non-failed cur_time[i]).
  - If round_idx==ROUNDS-1 → MATCH_END; otherwise round_idx++ → SHOW.
- MATCH_END (1 cycle):
  - avg_time[i] = sum[i]>>log2(ROUNDS).
  - winner = index of the lowest sum; ties go to the lowest index.
  - winner_valid=0 if every player failed every round; otherwise 1.
  - done=1 → SHOW. round_idx stays at ROUNDS-1 until the next match starts.
- Priority: rst_n > clr_best (may coincide with ROUND_END; clear wins) > FSM. start edges are ignored while busy=1.

Optional Feature:
- Macro: REACT_HOLD_CHECK_EN.
  - Defined: ARM holds (stays in ARM, delay not yet loaded) while any react bit is high; delay_cnt is loaded on the first cycle with react all 0. This prevents a held button from being misread or skipped.
  - Undefined: ARM always lasts exactly 1 cycle; held buttons generate no edge and are treated as non-responding.

Test Plan:
- N=2, ROUNDS=4, rand_val=0: start edge → led rises after 501 ticks. Player 0 edge at ms_cnt=120, player 1 at 250 → cur_time={250,120}, fail=0, round_idx→1.
- Player 1 edge during COUNTDOWN → fail[1]=1, cur_time[1]=10000. Player 0 responds at 200 → best_time=200.
- No react for 10000 ticks after led → fail=2'b11, both times 10000, led=0, best_time unchanged.
- Four rounds with player 0 times {100,200,300,400} and player 1 times {150,150,150,150} → done pulse, avg_time={150,250}, winner=1, winner_valid=1.
- Equal sums → winner=0. Every round all-fail → winner_valid=0.
- rst_n low mid-REACT → next cycle led=0, busy=0, best_time=16'hFFFF. clr_best during ROUND_END → best_time=16'hFFFF.
